multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/cpu_pkg.sv | 68 ++++++
 rtl/cond_eval.sv | 34 +++
 rtl/multicycle_controller.sv | 178 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcode classes,
// ALU function codes, write-back sources and the registered control word.
package cpu_pkg;

  typedef enum logic [3:0] {
    StReset     = 4'd0,
    StFetch     = 4'd1,
    StFetchWait = 4'd2,
    StDecode    = 4'd3,
    StExecute   = 4'd4,
    StWriteback = 4'd5,
    StMemAddr   = 4'd6,
    StMemWait   = 4'd7,
    StMemDone   = 4'd8,
    StHalt      = 4'd9
  } state_t;

  // Opcode classes: opcode[6] = 0 is data-processing, otherwise opcode[6:5] selects.
  localparam logic [6:0] OpNop       = 7'b0000000;
  localparam logic [6:0] OpHlt       = 7'b0000001;
  localparam logic [1:0] ClassMem    = 2'b10;
  localparam logic [1:0] ClassBranch = 2'b11;
  localparam logic [2:0] FuncCmp     = 3'b010;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOrr = 3'd3;
  localparam logic [2:0] AluXor = 3'd7;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbRam = 2'b01;
  localparam logic [1:0] WbPc  = 2'b10;

  typedef struct packed {
    logic       waiting;
    logic       sel_a;
    logic       sel_b;
    logic       sel_shift;
    logic       en_a;
    logic       en_b;
    logic       en_s;
    logic       en_c;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       load_ir;
    logic       load_pc;
    logic       sel_pc;
    logic       load_addr;
    logic       sel_addr;
    logic       ram_w_en;
  } ctrl_t;

  function automatic logic [2:0] alu_decode(input logic [2:0] func);
    logic [2:0] op;
    case (func)
      3'b000:  op = AluAdd;
      3'b001:  op = AluSub;
      3'b010:  op = AluSub;
      3'b011:  op = AluAnd;
      3'b100:  op = AluOrr;
      3'b101:  op = AluXor;
      default: op = AluAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code check: decides whether an instruction executes given its
// cond field and the NZCV flags.
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'h0: pass = z;
      4'h1: pass = ~z;
      4'h2: pass = c;
      4'h3: pass = ~c;
      4'h4: pass = n;
      4'h5: pass = ~n;
      4'h6: pass = v;
      4'h7: pass = ~v;
      4'h8: pass = c & ~z;
      4'h9: pass = ~c | z;
      4'ha: pass = (n == v);
      4'hb: pass = (n != v);
      4'hc: pass = ~z & (n == v);
      4'hd: pass = z | (n != v);
      4'he: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, write-back and
// memory access, driving registered datapath control strobes.
module multicycle_controller import cpu_pkg::*; #(
  parameter int unsigned RAM_WAIT = 1,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [6:0]          opcode,
  input  logic [3:0]          cond,
  input  logic [31:0]         status_reg,
  output logic                waiting,
  output logic                sel_A,
  output logic                sel_B,
  output logic                sel_shift,
  output logic                en_A,
  output logic                en_B,
  output logic                en_S,
  output logic                en_C,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic [1:0]          wb_sel,
  output logic                w_en,
  output logic                load_ir,
  output logic                load_pc,
  output logic                sel_pc,
  output logic                load_addr,
  output logic                sel_addr,
  output logic                ram_w_en
);

  localparam logic [3:0] FetchWaitLoad = 4'(RAM_WAIT);
  localparam logic [3:0] MemWaitLoad   = 4'(RAM_WAIT - 1);
  localparam ctrl_t      CtrlIdle      = '{waiting: 1'b1, default: '0};

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [ALU_OP_W-1:0]   alu_q, alu_d;
  logic                  cond_pass;
  logic                  is_mem, is_branch;
  logic                  unused_status;

  assign unused_status = ^status_reg[27:0];
  assign is_mem        = (opcode[6:5] == ClassMem);
  assign is_branch     = (opcode[6:5] == ClassBranch);

  cond_eval u_cond_eval (
    .cond (cond),
    .nzcv (status_reg[31:28]),
    .pass (cond_pass)
  );

  // Next state and wait counter; the counter is reloaded on every wait-state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        state_d = StFetchWait;
        cnt_d   = FetchWaitLoad;
      end
      StFetchWait: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = StDecode;
      end
      StDecode: begin
        if (!cond_pass || opcode == OpNop) state_d = StFetch;
        else if (opcode == OpHlt)          state_d = StHalt;
        else                               state_d = StExecute;
      end
      StExecute: begin
        if (!opcode[6])  state_d = StWriteback;
        else if (is_mem) state_d = StMemAddr;
        else             state_d = StFetch;
      end
      StWriteback: state_d = StFetch;
      StMemAddr: begin
        if (RAM_WAIT == 0) begin
          state_d = StMemDone;
        end else begin
          state_d = StMemWait;
          cnt_d   = MemWaitLoad;
        end
      end
      StMemWait: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = StMemDone;
      end
      StMemDone: state_d = StFetch;
      StHalt:    if (start) state_d = StFetch;
      default: begin
        state_d = StReset;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control word for the upcoming state, so every strobe leaves a flop.
  always_comb begin
    ctrl_d = '0;
    alu_d  = '0;
    case (state_d)
      StReset, StHalt: ctrl_d.waiting = 1'b1;
      StFetchWait: begin
        if (cnt_d == 4'd0) begin
          ctrl_d.load_ir = 1'b1;
          ctrl_d.load_pc = 1'b1;
        end
      end
      StExecute: begin
        ctrl_d.en_a      = opcode[3];
        ctrl_d.sel_a     = opcode[3];
        ctrl_d.en_b      = opcode[4];
        ctrl_d.sel_b     = opcode[4];
        ctrl_d.en_s      = opcode[4];
        ctrl_d.sel_shift = opcode[5];
        ctrl_d.en_c      = 1'b1;
        alu_d            = ALU_OP_W'(opcode[6] ? AluAdd : alu_decode(opcode[2:0]));
        if (is_branch) begin
          ctrl_d.load_pc = 1'b1;
          ctrl_d.sel_pc  = 1'b1;
        end
      end
      StWriteback: begin
        ctrl_d.wb_sel = WbAlu;
        // CMP is the 010 subtract; bit 3 only picks operand A.
        ctrl_d.w_en   = (opcode[2:0] != FuncCmp);
      end
      StMemAddr: ctrl_d.load_addr = 1'b1;
      StMemWait: ctrl_d.sel_addr  = 1'b1;
      StMemDone: begin
        ctrl_d.sel_addr = 1'b1;
        if (opcode[0]) begin
          ctrl_d.wb_sel = WbRam;
          ctrl_d.w_en   = 1'b1;
        end else begin
          ctrl_d.ram_w_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
      cnt_q   <= 4'd0;
      ctrl_q  <= CtrlIdle;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
    end
  end

  assign waiting   = ctrl_q.waiting;
  assign sel_A     = ctrl_q.sel_a;
  assign sel_B     = ctrl_q.sel_b;
  assign sel_shift = ctrl_q.sel_shift;
  assign en_A      = ctrl_q.en_a;
  assign en_B      = ctrl_q.en_b;
  assign en_S      = ctrl_q.en_s;
  assign en_C      = ctrl_q.en_c;
  assign ALU_op    = alu_q;
  assign wb_sel    = ctrl_q.wb_sel;
  assign w_en      = ctrl_q.w_en;
  assign load_ir   = ctrl_q.load_ir;
  assign load_pc   = ctrl_q.load_pc;
  assign sel_pc    = ctrl_q.sel_pc;
  assign load_addr = ctrl_q.load_addr;
  assign sel_addr  = ctrl_q.sel_addr;
  assign ram_w_en  = ctrl_q.ram_w_en;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: dut_a uses RAM_WAIT=1, dut_b RAM_WAIT=3;
// every check compares a full 20-bit output word against a hand-built expectation.
module tb_multicycle_controller;

  // Output word layout (MSB..LSB): waiting sel_A sel_B sel_shift en_A en_B en_S en_C
  // ALU_op[2:0] wb_sel[1:0] w_en load_ir load_pc sel_pc load_addr sel_addr ram_w_en
  localparam logic [19:0] BWait  = 20'h80000;
  localparam logic [19:0] BSelA  = 20'h40000;
  localparam logic [19:0] BSelB  = 20'h20000;
  localparam logic [19:0] BSsh   = 20'h10000;
  localparam logic [19:0] BEnA   = 20'h08000;
  localparam logic [19:0] BEnB   = 20'h04000;
  localparam logic [19:0] BEnS   = 20'h02000;
  localparam logic [19:0] BEnC   = 20'h01000;
  localparam logic [19:0] BSub   = 20'h00200;
  localparam logic [19:0] BWbRam = 20'h00080;
  localparam logic [19:0] BWen   = 20'h00040;
  localparam logic [19:0] BLir   = 20'h00020;
  localparam logic [19:0] BLpc   = 20'h00010;
  localparam logic [19:0] BSpc   = 20'h00008;
  localparam logic [19:0] BLaddr = 20'h00004;
  localparam logic [19:0] BSaddr = 20'h00002;
  localparam logic [19:0] BRamw  = 20'h00001;

  localparam logic [6:0] OpAdd = 7'b0011000;
  localparam logic [6:0] OpCmp = 7'b0011010;
  localparam logic [6:0] OpHlt = 7'b0000001;
  localparam logic [6:0] OpBr  = 7'b1100000;
  localparam logic [6:0] OpStr = 7'b1000000;
  localparam logic [6:0] OpLdr = 7'b1000001;
  localparam logic [3:0] CondEq = 4'h0;
  localparam logic [3:0] CondAl = 4'he;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [6:0]  opcode;
  logic [3:0]  cond;
  logic [31:0] status_reg;

  logic a_waiting, a_sel_A, a_sel_B, a_sel_shift, a_en_A, a_en_B, a_en_S, a_en_C;
  logic a_w_en, a_load_ir, a_load_pc, a_sel_pc, a_load_addr, a_sel_addr, a_ram_w_en;
  logic [2:0] a_ALU_op;
  logic [1:0] a_wb_sel;
  logic b_waiting, b_sel_A, b_sel_B, b_sel_shift, b_en_A, b_en_B, b_en_S, b_en_C;
  logic b_w_en, b_load_ir, b_load_pc, b_sel_pc, b_load_addr, b_sel_addr, b_ram_w_en;
  logic [2:0] b_ALU_op;
  logic [1:0] b_wb_sel;
  logic [19:0] va, vb;

  int n_checks = 0;
  int n_errors = 0;
  int a_wen_n  = 0;
  int a_act_n  = 0;
  int b_sel_n  = 0;
  int b_ramw_n = 0;
  int snap_a, snap_b;

  always #5 clk = ~clk;

  multicycle_controller #(.RAM_WAIT(1), .ALU_OP_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .cond(cond),
    .status_reg(status_reg), .waiting(a_waiting), .sel_A(a_sel_A), .sel_B(a_sel_B),
    .sel_shift(a_sel_shift), .en_A(a_en_A), .en_B(a_en_B), .en_S(a_en_S), .en_C(a_en_C),
    .ALU_op(a_ALU_op), .wb_sel(a_wb_sel), .w_en(a_w_en), .load_ir(a_load_ir),
    .load_pc(a_load_pc), .sel_pc(a_sel_pc), .load_addr(a_load_addr),
    .sel_addr(a_sel_addr), .ram_w_en(a_ram_w_en)
  );

  multicycle_controller #(.RAM_WAIT(3), .ALU_OP_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .cond(cond),
    .status_reg(status_reg), .waiting(b_waiting), .sel_A(b_sel_A), .sel_B(b_sel_B),
    .sel_shift(b_sel_shift), .en_A(b_en_A), .en_B(b_en_B), .en_S(b_en_S), .en_C(b_en_C),
    .ALU_op(b_ALU_op), .wb_sel(b_wb_sel), .w_en(b_w_en), .load_ir(b_load_ir),
    .load_pc(b_load_pc), .sel_pc(b_sel_pc), .load_addr(b_load_addr),
    .sel_addr(b_sel_addr), .ram_w_en(b_ram_w_en)
  );

  assign va = {a_waiting, a_sel_A, a_sel_B, a_sel_shift, a_en_A, a_en_B, a_en_S, a_en_C,
               a_ALU_op, a_wb_sel, a_w_en, a_load_ir, a_load_pc, a_sel_pc, a_load_addr,
               a_sel_addr, a_ram_w_en};
  assign vb = {b_waiting, b_sel_A, b_sel_B, b_sel_shift, b_en_A, b_en_B, b_en_S, b_en_C,
               b_ALU_op, b_wb_sel, b_w_en, b_load_ir, b_load_pc, b_sel_pc, b_load_addr,
               b_sel_addr, b_ram_w_en};

  always @(negedge clk) begin
    if (a_w_en) a_wen_n++;
    if (a_en_A | a_en_B | a_en_S | a_en_C | a_w_en) a_act_n++;
    if (b_sel_addr) b_sel_n++;
    if (b_ram_w_en) b_ramw_n++;
  end

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in the FETCH cycle, ends in the final fetch cycle (load_ir/load_pc).
  task automatic fetch_chk(input string tag, input bit use_b, input int waits);
    for (int i = 0; i <= waits + 1; i++) begin
      if (i != 0) step();
      check(tag, use_b ? vb : va, (i == waits + 1) ? (BLir | BLpc) : 20'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = OpAdd; cond = CondAl; status_reg = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", va, BWait);
    check("reset_b", vb, BWait);
    rst_n = 1'b1;

    // ADD, cond AL: 6-cycle instruction on dut_a
    step();
    fetch_chk("add_fetch", 1'b0, 1);
    step(); check("add_decode", va, 20'h0);
    step(); check("add_exec", va, BSelA | BSelB | BEnA | BEnB | BEnS | BEnC);
    step(); check("add_wb", va, BWen);
    step();
    opcode = OpCmp; snap_a = a_wen_n;

    // CMP: SUB into C, no register write
    fetch_chk("cmp_fetch", 1'b0, 1);
    step(); check("cmp_decode", va, 20'h0);
    step(); check("cmp_exec", va, BSelA | BSelB | BEnA | BEnB | BEnS | BEnC | BSub);
    step(); check("cmp_wb", va, 20'h0);
    step(); check("cmp_wen_count", 20'(a_wen_n - snap_a), 20'h0);
    opcode = OpAdd; cond = CondEq; snap_a = a_act_n;

    // EQ with Z=0: skipped, straight back to FETCH
    fetch_chk("eq_fetch", 1'b0, 1);
    step(); check("eq_decode", va, 20'h0);
    step();
    opcode = OpHlt; cond = CondAl;
    fetch_chk("eq_refetch", 1'b0, 1);
    check("eq_activity", 20'(a_act_n - snap_a), 20'h0);

    // HLT, then start after 5 cycles in HALT
    step(); check("hlt_decode", va, 20'h0);
    step(); check("hlt_enter", va, BWait);
    for (int i = 0; i < 5; i++) begin
      step(); check("hlt_hold", va, BWait);
    end
    start = 1'b1; opcode = OpBr;
    step(); start = 1'b0;
    check("hlt_exit", va, 20'h0);

    // Branch: PC loaded from C during EXECUTE
    fetch_chk("br_fetch", 1'b0, 1);
    step(); check("br_decode", va, 20'h0);
    step(); check("br_exec", va, BSsh | BEnC | BLpc | BSpc);
    step(); check("br_next", va, 20'h0);

    // Store on dut_b (RAM_WAIT=3)
    rst_n = 1'b0; opcode = OpStr;
    #1;
    check("rst2_a", va, BWait);
    check("rst2_b", vb, BWait);
    step();
    rst_n = 1'b1;
    step();
    fetch_chk("st_fetch", 1'b1, 3);
    step(); check("st_decode", vb, 20'h0);
    step(); check("st_exec", vb, BEnC);
    step(); check("st_addr", vb, BLaddr);
    snap_b = b_sel_n; snap_a = b_ramw_n;
    for (int i = 0; i < 4; i++) begin
      step(); check("st_mem", vb, (i == 3) ? (BSaddr | BRamw) : BSaddr);
    end
    step(); check("st_next", vb, 20'h0);
    check("st_sel_count", 20'(b_sel_n - snap_b), 20'd4);
    check("st_ramw_count", 20'(b_ramw_n - snap_a), 20'd1);

    // Reset in MEM_WAIT of a store aborts the write
    snap_b = b_ramw_n;
    fetch_chk("st2_fetch", 1'b1, 3);
    step(); step();
    step(); check("st2_addr", vb, BLaddr);
    step(); check("st2_wait", vb, BSaddr);
    rst_n = 1'b0;
    #1;
    check("rst_mid", vb, BWait);
    opcode = OpLdr;
    step(); check("rst_mid_hold", vb, BWait);
    rst_n = 1'b1;
    step(); check("rst_restart", vb, 20'h0);

    // Load after restart: RAM data written back
    fetch_chk("ld_fetch", 1'b1, 3);
    step(); check("ld_decode", vb, 20'h0);
    step(); check("ld_exec", vb, BEnC);
    step(); check("ld_addr", vb, BLaddr);
    for (int i = 0; i < 3; i++) begin
      step(); check("ld_wait", vb, BSaddr);
    end
    step(); check("ld_done", vb, BSaddr | BWbRam | BWen);
    step(); check("ld_next", vb, 20'h0);
    check("abort_ramw_count", 20'(b_ramw_n - snap_b), 20'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
